// File: rtl/regfile_sequencer.sv
// Micro-op sequencer in front of the 16-entry register block: reads two operands, waits on the
// execute unit, writes the result back and bumps PC (id 4'hC). Sole driver of all register ids.
//   state  | meaning
//   IDLE   | ready for a request
//   READ   | drive src ids, capture operands
//   EXEC   | operands valid, wait for result or timeout
//   WB     | write result to dst (unmapped dst aborts)
//   PC     | PC <= PC + PC_STEP
//   DONE   | retire pulse
//   ERR    | abort pulse
module regfile_sequencer #(
    parameter logic [7:0] PC_STEP = 8'd1,
    parameter logic [3:0] PARK_ID = 4'hF,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_src1,
    input  logic [3:0] req_src2,
    input  logic [3:0] req_dst,
    input  logic       req_wb,
    output logic [3:0] read1_id,
    input  logic [7:0] read1_value,
    output logic [3:0] read2_id,
    input  logic [7:0] read2_value,
    output logic [3:0] write_id,
    output logic [7:0] write_value,
    output logic       write_en,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       op_valid,
    input  logic       result_valid,
    input  logic [7:0] result_data,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] PC_ID = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_PC,
        S_DONE,
        S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] src1_q, src1_d;
    logic [3:0] src2_q, src2_d;
    logic [3:0] dst_q, dst_d;
    logic       wb_q, wb_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic [7:0] res_q, res_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src1_q  <= 4'h0;
            src2_q  <= 4'h0;
            dst_q   <= 4'h0;
            wb_q    <= 1'b0;
            op_a_q  <= 8'h00;
            op_b_q  <= 8'h00;
            res_q   <= 8'h00;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            dst_q   <= dst_d;
            wb_q    <= wb_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        dst_d       = dst_q;
        wb_d        = wb_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        req_ready   = 1'b0;
        read1_id    = 4'h0;
        read2_id    = 4'h0;
        write_id    = PARK_ID;
        write_value = 8'h00;
        write_en    = 1'b0;
        op_valid    = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    src1_d  = req_src1;
                    src2_d  = req_src2;
                    dst_d   = req_dst;
                    wb_d    = req_wb;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                read1_id = src1_q;
                read2_id = src2_q;
                op_a_d   = read1_value;
                op_b_d   = read2_value;
                cnt_d    = 8'h00;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                op_valid = 1'b1;
                cnt_d    = cnt_q + 8'd1;
                // A result arriving on the last allowed cycle still beats the timeout.
                if (result_valid) begin
                    res_d   = result_data;
                    cnt_d   = 8'h00;
                    state_d = wb_q ? S_WB : S_PC;
                end else if ((cnt_q + 8'd1) == TIMEOUT) begin
                    cnt_d   = 8'h00;
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                if (dst_q > PC_ID) begin
                    state_d = S_ERR;
                end else begin
                    write_en    = 1'b1;
                    write_id    = dst_q;
                    write_value = res_q;
                    // A write to PC is a branch target, so the increment is skipped.
                    state_d     = (dst_q == PC_ID) ? S_DONE : S_PC;
                end
            end
            S_PC: begin
                read1_id    = PC_ID;
                write_en    = 1'b1;
                write_id    = PC_ID;
                write_value = read1_value + PC_STEP;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The register block samples write_en on the same edge that applies reset.
        if (reset) begin
            write_en    = 1'b0;
            write_id    = PARK_ID;
            write_value = 8'h00;
        end
    end

    assign op_a = op_a_q;
    assign op_b = op_b_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 16-entry register block.
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_src1, req_src2, req_dst;
    logic       req_wb;
    logic [3:0] read1_id, read2_id, write_id;
    logic [7:0] read1_value, read2_value, write_value;
    logic       write_en;
    logic [7:0] op_a, op_b;
    logic       op_valid;
    logic       result_valid;
    logic [7:0] result_data;
    logic       done, err;

    int total = 0;
    int bad   = 0;

    logic [7:0] rf [16];
    int         wcnt [16];
    int         wtot = 0;
    logic       ld_en;
    logic [3:0] ld_id;
    logic [7:0] ld_val;

    always #5 clk = ~clk;

    regfile_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .req_wb(req_wb),
        .read1_id(read1_id), .read1_value(read1_value),
        .read2_id(read2_id), .read2_value(read2_value),
        .write_id(write_id), .write_value(write_value), .write_en(write_en),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
        .result_valid(result_valid), .result_data(result_data),
        .done(done), .err(err)
    );

    assign read1_value = rf[read1_id];
    assign read2_value = rf[read2_id];

    always @(posedge clk) begin
        if (ld_en) rf[ld_id] <= ld_val;
        if (write_en) begin
            rf[write_id]   <= write_value;
            wcnt[write_id] <= wcnt[write_id] + 1;
            wtot           <= wtot + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [3:0] id, input logic [7:0] val);
        ld_en  = 1'b1;
        ld_id  = id;
        ld_val = val;
        @(negedge clk);
        ld_en  = 1'b0;
    endtask

    // Issues one request at a negedge and returns at the negedge where done or err is seen.
    // lat counts rising edges from the accepting edge to that sample.
    task automatic do_op(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                         input logic w, input logic [7:0] res, input int wait_n,
                         output int lat, output logic dn, output logic er,
                         output logic [7:0] a, output logic [7:0] b);
        int execn;
        bit seen;
        req_src1  = s1;
        req_src2  = s2;
        req_dst   = d;
        req_wb    = w;
        req_valid = 1'b1;
        dn = 1'b0; er = 1'b0; a = 8'h00; b = 8'h00;
        execn = 0; seen = 1'b0; lat = 0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 600; i++) begin
            if (done) begin dn = 1'b1; break; end
            if (err) begin er = 1'b1; break; end
            result_valid = 1'b0;
            if (op_valid) begin
                if (!seen) begin a = op_a; b = op_b; seen = 1'b1; end
                if (execn == wait_n) begin
                    result_valid = 1'b1;
                    result_data  = res;
                end
                execn++;
            end
            @(negedge clk);
            lat++;
        end
        result_valid = 1'b0;
        chk("op_bound", {31'd0, dn | er}, 32'd1);
    endtask

    int         lat;
    logic       dn, er;
    logic [7:0] a, b;
    int         w0, wt0;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_src1 = 4'h0; req_src2 = 4'h0; req_dst = 4'h0;
        req_wb = 1'b0; result_valid = 1'b0; result_data = 8'h00;
        ld_en = 1'b0; ld_id = 4'h0; ld_val = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_opv", {31'd0, op_valid}, 32'd0);
        chk("rst_wen", {31'd0, write_en}, 32'd0);
        chk("rst_wid", {28'd0, write_id}, 32'hF);
        chk("rst_wval", {24'd0, write_value}, 32'h0);
        chk("rst_rid", {24'd0, read1_id, read2_id}, 32'h0);
        chk("rst_opab", {16'd0, op_a, op_b}, 32'h0);
        chk("rst_pulse", {30'd0, done, err}, 32'd0);
        reset = 1'b0;

        load(4'h0, 8'h00); load(4'h1, 8'h10); load(4'h2, 8'h22);
        load(4'h3, 8'h00); load(4'h4, 8'h44); load(4'h5, 8'h5A); load(4'hC, 8'h40);

        // 1: basic op with writeback
        w0 = wcnt[3];
        do_op(4'h1, 4'h2, 4'h3, 1'b1, 8'h32, 0, lat, dn, er, a, b);
        chk("t1_done", {31'd0, dn}, 32'd1);
        chk("t1_lat", lat, 32'd5);
        chk("t1_opa", {24'd0, a}, 32'h10);
        chk("t1_opb", {24'd0, b}, 32'h22);
        chk("t1_r3", {24'd0, rf[3]}, 32'h32);
        chk("t1_r3_writes", wcnt[3] - w0, 32'd1);
        chk("t1_pc", {24'd0, rf[12]}, 32'h41);
        @(negedge clk);
        chk("t1_ready", {31'd0, req_ready}, 32'd1);
        chk("t1_done_pulse", {31'd0, done}, 32'd0);

        // 2: no writeback, PC wraps
        load(4'hC, 8'hFF);
        w0 = wcnt[3];
        do_op(4'h1, 4'h2, 4'h3, 1'b0, 8'h55, 0, lat, dn, er, a, b);
        chk("t2_done", {31'd0, dn}, 32'd1);
        chk("t2_lat", lat, 32'd4);
        chk("t2_r3", {24'd0, rf[3]}, 32'h32);
        chk("t2_r3_writes", wcnt[3] - w0, 32'd0);
        chk("t2_pc", {24'd0, rf[12]}, 32'h00);
        @(negedge clk);

        // 3: writeback to PC acts as branch
        w0 = wcnt[12];
        do_op(4'h1, 4'h2, 4'hC, 1'b1, 8'h80, 0, lat, dn, er, a, b);
        chk("t3_done", {31'd0, dn}, 32'd1);
        chk("t3_lat", lat, 32'd4);
        chk("t3_pc", {24'd0, rf[12]}, 32'h80);
        chk("t3_pc_writes", wcnt[12] - w0, 32'd1);
        @(negedge clk);

        // 4: unmapped destination aborts
        wt0 = wtot;
        do_op(4'h1, 4'h2, 4'hE, 1'b1, 8'h99, 0, lat, dn, er, a, b);
        chk("t4_err", {30'd0, dn, er}, 32'd1);
        chk("t4_lat", lat, 32'd4);
        chk("t4_writes", wtot - wt0, 32'd0);
        chk("t4_pc", {24'd0, rf[12]}, 32'h80);
        @(negedge clk);
        chk("t4_ready", {31'd0, req_ready}, 32'd1);

        // 5: timeout, then result on the final allowed cycle
        wt0 = wtot;
        do_op(4'h1, 4'h2, 4'h3, 1'b1, 8'h77, 1000, lat, dn, er, a, b);
        chk("t5_err", {30'd0, dn, er}, 32'd1);
        chk("t5_lat", lat, 32'd257);
        chk("t5_opv", {31'd0, op_valid}, 32'd0);
        chk("t5_writes", wtot - wt0, 32'd0);
        @(negedge clk);
        w0 = wcnt[4];
        do_op(4'h1, 4'h2, 4'h4, 1'b0, 8'h66, 254, lat, dn, er, a, b);
        chk("t5b_done", {31'd0, dn}, 32'd1);
        chk("t5b_lat", lat, 32'd258);
        chk("t5b_pc", {24'd0, rf[12]}, 32'h81);
        chk("t5b_r4_writes", wcnt[4] - w0, 32'd0);
        @(negedge clk);

        // 6a: reset during EXEC
        req_src1 = 4'h1; req_src2 = 4'h2; req_dst = 4'h3; req_wb = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("t6a_in_exec", {31'd0, op_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6a_ready", {31'd0, req_ready}, 32'd1);
        chk("t6a_opv", {31'd0, op_valid}, 32'd0);
        chk("t6a_wen", {31'd0, write_en}, 32'd0);
        chk("t6a_wid", {28'd0, write_id}, 32'hF);
        chk("t6a_opa", {24'd0, op_a}, 32'h0);

        // 6b: reset during WB
        @(negedge clk);
        w0 = wcnt[5]; wt0 = wtot;
        req_src1 = 4'h1; req_src2 = 4'h2; req_dst = 4'h5; req_wb = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        result_valid = 1'b1; result_data = 8'h99;
        @(negedge clk);
        result_valid = 1'b0;
        chk("t6b_in_wb", {27'd0, write_en, write_id}, 32'h15);
        reset = 1'b1;
        #1;
        chk("t6b_wen_gated", {31'd0, write_en}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("t6b_ready", {31'd0, req_ready}, 32'd1);
        chk("t6b_wid", {28'd0, write_id}, 32'hF);
        chk("t6b_r5", {24'd0, rf[5]}, 32'h5A);
        chk("t6b_writes", wtot - wt0, 32'd0);
        chk("t6b_pc", {24'd0, rf[12]}, 32'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
